// File: rtl/rio_input_reader_pkg.sv
// Shared types and helpers for rio_input_reader: FSM state encoding,
// byte-enable width, segment sizing and byte-length to beat-count conversion.
package input_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2,
        ST_READ  = 2'd3
    } ir_state_e;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int KEEP_W         = DATA_WIDTH_DEF / 8;

    // Number of bus beats that fill one output sub-packet.
    function automatic int beats_per_seg(input int seg_bytes, input int keep_w);
        return seg_bytes / keep_w;
    endfunction

    // Beats needed for a packet whose length field holds (bytes - 1);
    // shift is log2 of the bytes carried per beat.
    function automatic logic [31:0] len_to_beats(input logic [31:0] len_m1, input int shift);
        return (len_m1 >> shift) + 32'd1;
    endfunction

endpackage

// File: rtl/rio_input_reader_if.sv
// Bus bundle for rio_input_reader: byte-enable-qualified input packet side,
// fetch request and the AXI4-Stream replay side.
// Handshakes: an input beat transfers on data_valid_in & data_ready_out; an
// output beat transfers on output_tvalid & output_tready, and while
// output_tvalid is high without output_tready every output field holds.
interface rio_input_reader_if #(
    parameter int DATA_WIDTH        = 64,
    parameter int DATA_LENGTH_WIDTH = 20
);
    logic [DATA_WIDTH-1:0]        data_in;
    logic                         data_valid_in;
    logic                         data_first_in;
    logic [DATA_WIDTH/8-1:0]      data_keep_in;
    logic [DATA_LENGTH_WIDTH-1:0] data_len_in;
    logic                         data_last_in;
    logic                         data_ready_out;
    logic                         ack_o;
    logic                         fetch_data_in;
    logic                         output_tready;
    logic [DATA_WIDTH-1:0]        output_tdata;
    logic                         output_tvalid;
    logic [DATA_WIDTH/8-1:0]      output_tkeep;
    logic                         output_tlast;
    logic                         output_pack_tfisrt;
    logic                         output_pack_tlast;

    // Source / sink side (user logic or testbench).
    modport master (
        output data_in, data_valid_in, data_first_in, data_keep_in, data_len_in,
               data_last_in, fetch_data_in, output_tready,
        input  data_ready_out, ack_o, output_tdata, output_tvalid, output_tkeep,
               output_tlast, output_pack_tfisrt, output_pack_tlast
    );

    // Buffer side.
    modport slave (
        input  data_in, data_valid_in, data_first_in, data_keep_in, data_len_in,
               data_last_in, fetch_data_in, output_tready,
        output data_ready_out, ack_o, output_tdata, output_tvalid, output_tkeep,
               output_tlast, output_pack_tfisrt, output_pack_tlast
    );
endinterface

// File: rtl/rio_input_reader_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output (1-cycle read latency). Read data holds while re is low.
module ir_sdp_ram #(
    parameter int WIDTH      = 72,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/rio_input_reader.sv
// rio_input_reader: captures one input packet into RAM, then replays it as an
// AXI4-Stream split into sub-packets of at most SEG_BYTES bytes.
// Optional macro INPUT_READER_LEN_CHECK_EN: discard a packet whose beat count
// disagrees with its length field (no ack, back to IDLE).
module rio_input_reader
    import input_reader_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int DATA_LENGTH_WIDTH = 20,
    parameter int RAM_ADDR_WIDTH    = 10,
    parameter int SEG_BYTES         = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    rio_input_reader_if.slave            bus,
    output ir_state_e                    dbg_state_o,
    output logic [RAM_ADDR_WIDTH:0]      dbg_beat_cnt_o,
    output logic [DATA_LENGTH_WIDTH-1:0] dbg_len_o
);
    localparam int KW  = DATA_WIDTH / 8;
    localparam int BPS = beats_per_seg(SEG_BYTES, KW);
    localparam int RW  = DATA_WIDTH + KW;
    localparam logic [RAM_ADDR_WIDTH:0] DEPTH = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};
    localparam logic [RAM_ADDR_WIDTH:0] ONE   = {{RAM_ADDR_WIDTH{1'b0}}, 1'b1};
`ifdef INPUT_READER_LEN_CHECK_EN
    localparam int KSHIFT = $clog2(KW);
`endif

    ir_state_e                    state_q;
    logic                         ready_q;
    logic                         ack_q;
    logic [RAM_ADDR_WIDTH:0]      beat_cnt_q;
    logic [DATA_LENGTH_WIDTH-1:0] len_q;

    logic [RAM_ADDR_WIDTH:0]      rd_ptr_q;
    logic [RAM_ADDR_WIDTH:0]      ram_idx_q;
    logic                         ram_vld_q;

    logic [DATA_WIDTH-1:0]        tdata_q;
    logic [KW-1:0]                tkeep_q;
    logic                         tvalid_q;
    logic                         tlast_q;
    logic                         pfirst_q;
    logic                         plast_q;

    logic                         in_fire;
    logic                         room;
    logic [RAM_ADDR_WIDTH:0]      cnt_next;
    logic                         len_ok;
    logic                         ram_we;
    logic [RAM_ADDR_WIDTH-1:0]    ram_waddr;
    logic [RW-1:0]                ram_wdata;
    logic                         ram_re;
    logic [RW-1:0]                ram_rdata;
    logic                         rd_go;
    logic                         out_load;
    logic                         out_fire;
    logic                         idx_last;
    logic                         idx_seg_end;
`ifdef INPUT_READER_LEN_CHECK_EN
    logic [DATA_LENGTH_WIDTH-1:0] len_eff;
`endif

    // Capture-side decode: accepted beat, its RAM slot and the running count.
    always_comb begin
        in_fire   = bus.data_valid_in & ready_q;
        room      = (beat_cnt_q < DEPTH);
        cnt_next  = bus.data_first_in ? ONE : (room ? beat_cnt_q + ONE : beat_cnt_q);
        ram_we    = in_fire & (bus.data_first_in | ((state_q == ST_WRITE) & room));
        ram_waddr = bus.data_first_in ? '0 : beat_cnt_q[RAM_ADDR_WIDTH-1:0];
        ram_wdata = {bus.data_keep_in, bus.data_in};
`ifdef INPUT_READER_LEN_CHECK_EN
        len_eff   = bus.data_first_in ? bus.data_len_in : len_q;
        len_ok    = (32'(cnt_next) == len_to_beats(32'(len_eff), KSHIFT));
`else
        len_ok    = 1'b1;
`endif
    end

    // Replay-side decode: the RAM output stage refills whenever it is empty
    // or its beat moves into the output register, which keeps the stream
    // gap-free under continuous ready. The first read is launched from FULL
    // as soon as fetch is seen, hiding the RAM latency.
    always_comb begin
        out_fire    = tvalid_q & bus.output_tready;
        out_load    = ram_vld_q & (~tvalid_q | bus.output_tready);
        rd_go       = (state_q == ST_READ) | ((state_q == ST_FULL) & bus.fetch_data_in);
        ram_re      = rd_go & (~ram_vld_q | out_load) & (rd_ptr_q < beat_cnt_q);
        idx_last    = (ram_idx_q == beat_cnt_q - ONE);
        idx_seg_end = ((int'(ram_idx_q) % BPS) == (BPS - 1));
    end

    // Packet FSM with registered ready/ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            ack_q      <= 1'b0;
            beat_cnt_q <= '0;
            len_q      <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_WRITE: begin
                    ready_q <= 1'b1;
                    if (in_fire && (bus.data_first_in || state_q == ST_WRITE)) begin
                        beat_cnt_q <= cnt_next;
                        if (bus.data_first_in) len_q <= bus.data_len_in;
                        if (bus.data_last_in) begin
                            if (len_ok) begin
                                state_q <= ST_FULL;
                                ready_q <= 1'b0;
                                ack_q   <= 1'b1;
                            end else begin
                                state_q    <= ST_IDLE;
                                beat_cnt_q <= '0;
                            end
                        end else begin
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_FULL: begin
                    if (bus.fetch_data_in) state_q <= ST_READ;
                end
                ST_READ: begin
                    if (out_fire && plast_q) begin
                        state_q    <= ST_IDLE;
                        ready_q    <= 1'b1;
                        beat_cnt_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Replay pipeline: read pointer, RAM output stage and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            ram_idx_q <= '0;
            ram_vld_q <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            pfirst_q  <= 1'b0;
            plast_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                rd_ptr_q  <= '0;
                ram_vld_q <= 1'b0;
            end else begin
                if (ram_re) begin
                    rd_ptr_q  <= rd_ptr_q + ONE;
                    ram_idx_q <= rd_ptr_q;
                end
                ram_vld_q <= ram_re | (ram_vld_q & ~out_load);
            end
            if (out_load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= ram_rdata[DATA_WIDTH-1:0];
                tkeep_q  <= ram_rdata[RW-1:DATA_WIDTH];
                pfirst_q <= (ram_idx_q == '0);
                plast_q  <= idx_last;
                tlast_q  <= idx_last | idx_seg_end;
            end else if (out_fire) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    ir_sdp_ram #(
        .WIDTH      (RW),
        .ADDR_WIDTH (RAM_ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_ptr_q[RAM_ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    assign bus.data_ready_out     = ready_q;
    assign bus.ack_o              = ack_q;
    assign bus.output_tdata       = tdata_q;
    assign bus.output_tkeep       = tkeep_q;
    assign bus.output_tvalid      = tvalid_q;
    assign bus.output_tlast       = tlast_q;
    assign bus.output_pack_tfisrt = pfirst_q;
    assign bus.output_pack_tlast  = plast_q;

    assign dbg_state_o    = state_q;
    assign dbg_beat_cnt_o = beat_cnt_q;
    assign dbg_len_o      = len_q;
endmodule

// File: tb/tb_rio_input_reader.sv
// Testbench for rio_input_reader. Honours INPUT_READER_LEN_CHECK_EN the same
// way the design does.
module tb_rio_input_reader;
    import input_reader_pkg::*;

    localparam int DW  = 64;
    localparam int LW  = 20;
    localparam int AW  = 10;
    localparam int SEG = 256;
    localparam int KW  = DW / 8;
    localparam int BPS = SEG / KW;
    localparam int EW  = DW + KW + 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    ir_state_e     dbg_state;
    logic [AW:0]   dbg_beat_cnt;
    logic [LW-1:0] dbg_len;

    rio_input_reader_if #(.DATA_WIDTH(DW), .DATA_LENGTH_WIDTH(LW)) bus();

    rio_input_reader #(
        .DATA_WIDTH        (DW),
        .DATA_LENGTH_WIDTH (LW),
        .RAM_ADDR_WIDTH    (AW),
        .SEG_BYTES         (SEG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .dbg_state_o    (dbg_state),
        .dbg_beat_cnt_o (dbg_beat_cnt),
        .dbg_len_o      (dbg_len)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] pkt_data[$];
    logic [KW-1:0] pkt_keep[$];

    // Expected replay of the current packet: beats in order, tlast at every
    // full segment and on the final beat, packet flags on first/final beat.
    task automatic expect_packet();
        int n;
        n = pkt_data.size();
        for (int i = 0; i < n; i++) begin
            logic tl, pf, pl;
            pf = (i == 0);
            pl = (i == n - 1);
            tl = (((i + 1) % BPS) == 0) || pl;
            exp_q.push_back({pkt_data[i], pkt_keep[i], tl, pf, pl});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.data_valid_in = 1'b0;
        bus.data_first_in = 1'b0;
        bus.data_last_in  = 1'b0;
        bus.data_in       = '0;
        bus.data_keep_in  = '0;
        bus.data_len_in   = '0;
    endtask

    task automatic make_plan_packet();
        pkt_data.delete();
        pkt_keep.delete();
        pkt_data.push_back(64'hff);
        pkt_keep.push_back(8'hf0);
        for (int i = 0; i < 32; i++) begin
            pkt_data.push_back(64'h100 + 64'(i));
            pkt_keep.push_back(8'hff);
        end
    endtask

    task automatic make_random_packet(input int n);
        pkt_data.delete();
        pkt_keep.delete();
        for (int i = 0; i < n; i++) begin
            pkt_data.push_back({$urandom, $urandom});
            pkt_keep.push_back(KW'($urandom_range(1, 255)));
        end
    endtask

    function automatic logic [LW-1:0] good_len(input int n);
        return LW'((n - 1) * KW + int'($urandom_range(0, KW - 1)));
    endfunction

    // Sends pkt_data/pkt_keep; checks ack pulse (or its absence) afterwards.
    task automatic send_packet(input logic [LW-1:0] len, input bit gaps, input bit exp_ack);
        int n, t;
        n = pkt_data.size();
        t = 0;
        while (bus.data_ready_out !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.data_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: data_ready_out=%b required 1", bus.data_ready_out);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.data_valid_in = 1'b0;
                bus.data_first_in = 1'b1;
                bus.data_last_in  = 1'b1;
                bus.data_in       = {$urandom, $urandom};
                @(negedge clk);
            end
            bus.data_valid_in = 1'b1;
            bus.data_first_in = (i == 0);
            bus.data_last_in  = (i == n - 1);
            bus.data_in       = pkt_data[i];
            bus.data_keep_in  = pkt_keep[i];
            bus.data_len_in   = len;
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if (bus.ack_o !== exp_ack) begin
            errors++;
            $display("FAIL ack_pulse: ack_o=%b required %b", bus.ack_o, exp_ack);
        end
        checks++;
        if (bus.data_ready_out !== !exp_ack) begin
            errors++;
            $display("FAIL ready_after_store: data_ready_out=%b required %b", bus.data_ready_out, !exp_ack);
        end
        @(negedge clk);
        checks++;
        if (bus.ack_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_single: ack_o=%b required 0", bus.ack_o);
        end
        if (exp_ack) expect_packet();
    endtask

    // Fetches and collects n beats. mode 0: tready held high, mode 1: stall
    // one cycle after beats 3, 9 and 13, mode 2: random tready.
    task automatic fetch_and_collect(input int n, input int mode);
        int got, cyc;
        bit stall_next, holding, rdy;
        logic [EW-1:0] held, obs, exp;
        got = 0; cyc = 0; stall_next = 0; holding = 0;
        bus.fetch_data_in = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.output_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_latency1: output_tvalid=%b required 0", bus.output_tvalid);
        end
        @(negedge clk);
        bus.fetch_data_in = 1'b0;
        checks++;
        if (bus.output_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL fetch_latency2: output_tvalid=%b required 1", bus.output_tvalid);
        end
        while (got < n && cyc < 1000) begin
            obs = {bus.output_tdata, bus.output_tkeep, bus.output_tlast,
                   bus.output_pack_tfisrt, bus.output_pack_tlast};
            if (holding) begin
                checks++;
                if (obs !== held || bus.output_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_stable: got %h valid=%b required %h valid=1", obs, bus.output_tvalid, held);
                end
            end
            if (mode == 0) begin
                checks++;
                if (bus.output_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL no_bubble: output_tvalid=%b required 1 at beat %0d", bus.output_tvalid, got);
                end
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = !stall_next;
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            stall_next = 0;
            bus.output_tready = rdy;
            holding = 0;
            if (bus.output_tvalid === 1'b1 && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_extra: got %h required no beat", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL beat[%0d]: got %h required %h", got, obs, exp);
                    end
                end
                got++;
                if (mode == 1 && (got == 3 || got == 9 || got == 13)) stall_next = 1;
            end else if (bus.output_tvalid === 1'b1) begin
                holding = 1;
                held = obs;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL collect_timeout: got %0d beats required %0d", got, n);
        end
        checks++;
        if (bus.output_tvalid !== 1'b0 || bus.data_ready_out !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL end_of_replay: tvalid=%b ready=%b state=%0d required 0 1 %0d",
                     bus.output_tvalid, bus.data_ready_out, dbg_state, ST_IDLE);
        end
        bus.output_tready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        bus.fetch_data_in = 1'b0;
        bus.output_tready = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.data_ready_out !== 1'b0 || bus.ack_o !== 1'b0 || bus.output_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b ack=%b tvalid=%b required 0 0 0",
                     bus.data_ready_out, bus.ack_o, bus.output_tvalid);
        end
        checks++;
        if (bus.output_tdata !== '0 || bus.output_tkeep !== '0 || bus.output_tlast !== 1'b0 ||
            bus.output_pack_tfisrt !== 1'b0 || bus.output_pack_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: tdata=%h tkeep=%h flags=%b%b%b required zeros", bus.output_tdata,
                     bus.output_tkeep, bus.output_tlast, bus.output_pack_tfisrt, bus.output_pack_tlast);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.data_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: data_ready_out=%b required 1", bus.data_ready_out);
        end
    endtask

    task automatic test_plan_packet();
        make_plan_packet();
        send_packet(LW'(263), 1'b0, 1'b1);
        fetch_and_collect(33, 0);
    endtask

    task automatic test_backpressure();
        make_plan_packet();
        send_packet(LW'(263), 1'b0, 1'b1);
        fetch_and_collect(33, 1);
    endtask

    task automatic test_fetch_gating();
        make_random_packet(10);
        send_packet(good_len(10), 1'b0, 1'b1);
        // Second packet offered while the buffer is full must be ignored.
        for (int i = 0; i < 6; i++) begin
            bus.data_valid_in = (i < 3);
            bus.data_first_in = (i == 0);
            bus.data_last_in  = (i == 2);
            bus.data_in       = {$urandom, $urandom};
            bus.data_keep_in  = 8'hff;
            @(negedge clk);
            checks++;
            if (bus.data_ready_out !== 1'b0 || bus.output_tvalid !== 1'b0 || bus.ack_o !== 1'b0 ||
                dbg_state !== ST_FULL) begin
                errors++;
                $display("FAIL fetch_gating: ready=%b tvalid=%b ack=%b state=%0d required 0 0 0 %0d",
                         bus.data_ready_out, bus.output_tvalid, bus.ack_o, dbg_state, ST_FULL);
            end
        end
        idle_inputs();
        checks++;
        if (dbg_beat_cnt !== 11'd10) begin
            errors++;
            $display("FAIL gating_count: beat_cnt=%0d required 10", dbg_beat_cnt);
        end
        fetch_and_collect(10, 0);
    endtask

    task automatic test_single_beat();
        make_random_packet(1);
        send_packet(LW'(7), 1'b0, 1'b1);
        fetch_and_collect(1, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            make_random_packet(5 + k * 30);
            send_packet(good_len(5 + k * 30), 1'b0, 1'b1);
            fetch_and_collect(5 + k * 30, 0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            int n;
            n = $urandom_range(1, 90);
            make_random_packet(n);
            send_packet(good_len(n), 1'b1, 1'b1);
            fetch_and_collect(n, 2);
        end
    endtask

    task automatic test_reset_mid_read();
        int t;
        make_random_packet(40);
        send_packet(good_len(40), 1'b0, 1'b1);
        bus.fetch_data_in = 1'b1;
        bus.output_tready = 1'b1;
        t = 0;
        while (bus.output_tvalid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        bus.fetch_data_in = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.output_tvalid !== 1'b0 || bus.output_tdata !== '0 || bus.output_tkeep !== '0 ||
            bus.output_tlast !== 1'b0 || bus.output_pack_tfisrt !== 1'b0 ||
            bus.output_pack_tlast !== 1'b0 || bus.ack_o !== 1'b0 || bus.data_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: tvalid=%b tdata=%h tkeep=%h ready=%b required all 0",
                     bus.output_tvalid, bus.output_tdata, bus.output_tkeep, bus.data_ready_out);
        end
        exp_q.delete();
        bus.output_tready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.data_ready_out !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL ready_after_abort: ready=%b state=%0d required 1 %0d",
                     bus.data_ready_out, dbg_state, ST_IDLE);
        end
        make_random_packet(12);
        send_packet(good_len(12), 1'b0, 1'b1);
        fetch_and_collect(12, 0);
    endtask

    task automatic test_len_check();
        make_random_packet(20);
`ifdef INPUT_READER_LEN_CHECK_EN
        send_packet(LW'(263), 1'b0, 1'b0);
        checks++;
        if (dbg_state !== ST_IDLE || bus.data_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL len_mismatch: state=%0d ready=%b required %0d 1",
                     dbg_state, bus.data_ready_out, ST_IDLE);
        end
        make_random_packet(6);
        send_packet(good_len(6), 1'b0, 1'b1);
        fetch_and_collect(6, 0);
`else
        send_packet(LW'(263), 1'b0, 1'b1);
        fetch_and_collect(20, 0);
`endif
    endtask

    // ---------------- main sequence + final report ----------------
    initial begin
        test_reset();
        test_plan_packet();
        test_backpressure();
        test_fetch_gating();
        test_single_beat();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        test_len_check();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d beats left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
